// File: rtl/i2c_master_controller_pkg.sv
// Shared types and constants for the I2C register-access master.
package i2c_master_controller_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK,
    RSTART, RADDR, RADDR_ACK, RDATA, MNACK, STOP
  } state_e;

  localparam logic       RW_WRITE = 1'b0;
  localparam logic       RW_READ  = 1'b1;
  localparam logic [6:0] DEFAULT_DEVICE_ADDRESS = 7'b0101010;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-period timer: splits each bit slot into four QUARTER-cycle phases
// and strobes q_end on the last cycle of every phase.
module i2c_scl_gen #(
  parameter int QUARTER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] phase,
  output logic       q_end
);
  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign q_end = en && (cnt_q == CW'(QUARTER - 1));
  assign phase = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (q_end) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_controller.sv
// I2C master: one register write or read per command against a fixed 7-bit
// slave address; bit timing comes from i2c_scl_gen.
module i2c_master_controller
  import i2c_master_controller_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = DEFAULT_DEVICE_ADDRESS,
  parameter int         QUARTER        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_out,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       out_write_enable,
  output logic       busy
);
  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic       rw_q, rw_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0] phase;
  logic       q_end, slot_end, smp, gen_en;

  assign gen_en = (state_q != IDLE);

  i2c_scl_gen #(.QUARTER(QUARTER)) u_scl_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (gen_en),
    .phase (phase),
    .q_end (q_end)
  );

  assign slot_end = q_end && (phase == 2'd3);
  assign smp      = q_end && (phase == 2'd2);

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    rsp_nack_d  = rsp_nack_q;
    rsp_rdata_d = rsp_rdata_q;
    // SDA is sampled once per slot, on the last cycle of SCL-high quarter 2
    if (smp) begin
      ack_d = sda_in;
      if (state_q == RDATA) rx_d = {rx_q[6:0], sda_in};
    end
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = START;
        rw_d    = cmd_rw;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        nack_d  = 1'b0;
        bit_d   = '0;
      end
      START: if (slot_end) begin
        state_d = ADDR;
        tx_d    = {DEVICE_ADDRESS, RW_WRITE};
      end
      RSTART: if (slot_end) begin
        state_d = RADDR;
        tx_d    = {DEVICE_ADDRESS, RW_READ};
      end
      ADDR, REG, WDATA, RADDR, RDATA: if (slot_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          case (state_q)
            ADDR:    state_d = ADDR_ACK;
            REG:     state_d = REG_ACK;
            WDATA:   state_d = WDATA_ACK;
            RADDR:   state_d = RADDR_ACK;
            default: state_d = MNACK;
          endcase
        end
      end
      ADDR_ACK, REG_ACK, WDATA_ACK, RADDR_ACK: if (slot_end) begin
        if (ack_q) begin
          state_d = STOP;
          nack_d  = 1'b1;
        end else begin
          case (state_q)
            ADDR_ACK: begin
              state_d = REG;
              tx_d    = {4'b0000, addr_q};
            end
            REG_ACK: if (rw_q == RW_READ) begin
              state_d = RSTART;
            end else begin
              state_d = WDATA;
              tx_d    = wdata_q;
            end
            RADDR_ACK: state_d = RDATA;
            default:   state_d = STOP;
          endcase
        end
      end
      MNACK: if (slot_end) state_d = STOP;
      STOP: if (slot_end) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_nack_d  = nack_q;
        if (rw_q == RW_READ && !nack_q) rsp_rdata_d = rx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // START holds SCL high throughout; RSTART first lifts SCL with SDA still high
  always_comb begin
    scl_out          = 1'b1;
    sda_out          = 1'b1;
    out_write_enable = 1'b1;
    case (state_q)
      START: sda_out = ~phase[1];
      RSTART: begin
        scl_out = (phase != 2'd0);
        sda_out = ~phase[1];
      end
      ADDR, REG, WDATA, RADDR: begin
        scl_out = phase[1];
        sda_out = tx_q[3'd7 - bit_q];
      end
      ADDR_ACK, REG_ACK, WDATA_ACK, RADDR_ACK, RDATA: begin
        scl_out          = phase[1];
        out_write_enable = 1'b0;
      end
      MNACK: scl_out = phase[1];
      STOP: begin
        scl_out = phase[1];
        sda_out = 1'b0;
      end
      default: ;
    endcase
    if (rst) begin
      scl_out          = 1'b1;
      sda_out          = 1'b1;
      out_write_enable = 1'b0;
    end
  end

  assign busy      = (state_q != IDLE) && !rst;
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench: two masters (QUARTER=4 and QUARTER=1) share one behavioural
// slave/bus monitor that logs START/STOP tokens and bytes seen on the line.
module tb_i2c_master_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd_valid = '0;
  logic       cmd_rw = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [1:0] cmd_ready, rsp_valid, rsp_nack, scl, sda_o, oe, busy, sda_in;
  logic [7:0] rsp_rdata [2];
  logic       slv_sda = 1'b1;
  int         sel = 0;

  always #5 clk = ~clk;

  assign sda_in[0] = oe[0] ? sda_o[0] : slv_sda;
  assign sda_in[1] = oe[1] ? sda_o[1] : slv_sda;

  i2c_master_controller #(.QUARTER(4)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_nack(rsp_nack[0]),
    .scl_out(scl[0]), .sda_in(sda_in[0]), .sda_out(sda_o[0]),
    .out_write_enable(oe[0]), .busy(busy[0])
  );

  i2c_master_controller #(.QUARTER(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_nack(rsp_nack[1]),
    .scl_out(scl[1]), .sda_in(sda_in[1]), .sda_out(sda_o[1]),
    .out_write_enable(oe[1]), .busy(busy[1])
  );

  int         n_chk = 0, n_err = 0;
  int         q_log[$];
  int         bitcnt = 0, byte_idx = 0, cyc = 0, rise_last = 0, bit_len = 0, rv_cnt = 0;
  logic       rd_mode = 1'b0, slave_tx = 1'b0, mack = 1'b0, nack_addr = 1'b0;
  logic [7:0] sh = '0, rd_byte = 8'h3C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int e[$]);
    chk({tag, "_len"}, q_log.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < q_log.size()) ? q_log[i] : -1, e[i]);
  endtask

  task automatic send(input int k, input logic rw, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid[k] = 1'b1;
    @(negedge clk);
    cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output logic nk, output logic [7:0] rd, output logic rdy);
    int n = 0;
    while (rsp_valid[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", rsp_valid[k], 1);
    nk = rsp_nack[k]; rd = rsp_rdata[k]; rdy = cmd_ready[k];
  endtask

  // Slave model: 256 = START/Sr token, 512 = STOP token, else a byte
  initial begin
    logic p_scl, p_sda, c_scl, c_sda;
    p_scl = 1'b1; p_sda = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      c_scl = scl[sel]; c_sda = sda_in[sel];
      if (rsp_valid[sel]) rv_cnt++;
      if (p_scl && c_scl && p_sda && !c_sda) begin
        q_log.push_back(256);
        bitcnt = 0; byte_idx = 0; rd_mode = 1'b0; slave_tx = 1'b0; slv_sda = 1'b1;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
        q_log.push_back(512);
        slv_sda = 1'b1;
      end else if (!p_scl && c_scl) begin
        if (bitcnt == 1 && byte_idx == 0) bit_len = cyc - rise_last;
        rise_last = cyc;
        if (bitcnt < 8) begin
          sh = {sh[6:0], c_sda};
          bitcnt++;
          if (bitcnt == 8) q_log.push_back(int'(sh));
        end else if (bitcnt == 8) begin
          if (slave_tx) mack = c_sda;
          bitcnt = 9;
        end
      end else if (p_scl && !c_scl) begin
        if (bitcnt == 8) begin
          if (slave_tx) slv_sda = 1'b1;
          else begin
            slv_sda = (nack_addr && byte_idx == 0) ? 1'b1 : 1'b0;
            if (byte_idx == 0) rd_mode = sh[0];
          end
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          byte_idx++;
          slave_tx = rd_mode && (byte_idx == 1);
          slv_sda = slave_tx ? rd_byte[7] : 1'b1;
        end else if (slave_tx && bitcnt >= 1 && bitcnt <= 7) begin
          slv_sda = rd_byte[7 - bitcnt];
        end
      end
      p_scl = c_scl; p_sda = c_sda;
    end
  end

  initial begin
    int         e[$];
    logic       nk, rdy;
    logic [7:0] rd;
    int         n, rv0;

    repeat (3) @(negedge clk);
    chk("rst_scl", scl[0], 1);
    chk("rst_sda", sda_o[0], 1);
    chk("rst_oe", oe[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", cmd_ready[0], 0);
    chk("rst_rsp_valid", rsp_valid[0], 0);
    chk("rst_rsp_nack", rsp_nack[0], 0);
    chk("rst_rdata", rsp_rdata[0], 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", cmd_ready[0], 1);
    chk("rel_busy", busy[0], 0);

    // write 0xA5 to register 3
    q_log.delete();
    send(0, 1'b0, 4'h3, 8'hA5);
    chk("wr_busy", busy[0], 1);
    chk("wr_ready_low", cmd_ready[0], 0);
    wait_rsp(0, nk, rd, rdy);
    chk("wr_nack", nk, 0);
    chk("wr_ready_at_rsp", rdy, 1);
    @(negedge clk);
    e = '{256, 'h54, 'h03, 'hA5, 512};
    chk_log("wr", e);
    chk("wr_bit_len", bit_len, 16);

    // read register 7, slave returns 0x3C
    q_log.delete(); rd_byte = 8'h3C; mack = 1'b0;
    send(0, 1'b1, 4'h7, 8'h00);
    wait_rsp(0, nk, rd, rdy);
    chk("rd_nack", nk, 0);
    chk("rd_data", rd, 8'h3C);
    @(negedge clk);
    e = '{256, 'h54, 'h07, 256, 'h55, 'h3C, 512};
    chk_log("rd", e);
    chk("rd_master_nack", mack, 1);

    // slave NACKs the address byte of a read
    q_log.delete(); nack_addr = 1'b1; rd_byte = 8'h99;
    send(0, 1'b1, 4'h2, 8'h00);
    wait_rsp(0, nk, rd, rdy);
    chk("nk_nack", nk, 1);
    chk("nk_rdata_kept", rd, 8'h3C);
    @(negedge clk);
    e = '{256, 'h54, 512};
    chk_log("nk", e);
    nack_addr = 1'b0;

    // cmd_valid held through the transfer; inputs change after acceptance
    q_log.delete(); rv0 = rv_cnt;
    @(negedge clk);
    cmd_rw = 1'b0; cmd_addr = 4'h9; cmd_wdata = 8'h6E; cmd_valid[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("hold_busy", busy[0], 1);
    cmd_addr = 4'hE; cmd_wdata = 8'hFF;
    wait_rsp(0, nk, rd, rdy);
    cmd_valid[0] = 1'b0;
    chk("hold_ready_at_rsp", rdy, 1);
    repeat (100) @(negedge clk);
    chk("hold_rsp_count", rv_cnt - rv0, 1);
    chk("hold_busy_after", busy[0], 0);
    chk("hold_ready_after", cmd_ready[0], 1);
    e = '{256, 'h54, 'h09, 'h6E, 512};
    chk_log("hold", e);

    // reset during the write-data byte
    q_log.delete();
    send(0, 1'b0, 4'h2, 8'h5A);
    n = 0;
    while (q_log.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", q_log.size() >= 3, 1);
    repeat (32) @(negedge clk);
    chk("mid_busy_before", busy[0], 1);
    rv0 = rv_cnt; rst = 1'b1;
    @(negedge clk);
    chk("mid_scl", scl[0], 1);
    chk("mid_oe", oe[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_rsp_valid", rsp_valid[0], 0);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    chk("mid_no_rsp", rv_cnt - rv0, 0);
    chk("mid_busy_after", busy[0], 0);
    chk("mid_ready_after", cmd_ready[0], 1);
    chk("mid_rdata_cleared", rsp_rdata[0], 8'h00);

    // QUARTER=1 master, same write
    sel = 1; bit_len = 0;
    repeat (2) @(negedge clk);
    q_log.delete();
    send(1, 1'b0, 4'h3, 8'hA5);
    wait_rsp(1, nk, rd, rdy);
    chk("q1_nack", nk, 0);
    @(negedge clk);
    e = '{256, 'h54, 'h03, 'hA5, 512};
    chk_log("q1", e);
    chk("q1_bit_len", bit_len, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_controller.md
I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 The block SHALL have parameter DEVICE_ADDRESS, default 7'b0101010, which is the 7-bit target slave address.
REQ-002 The block SHALL have parameter QUARTER, default 4 (minimum 1), which is the number of clk cycles per SCL quarter-period.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-007 The block SHALL have port cmd_rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 The block SHALL have port cmd_addr, input, 4 bits: register address.
REQ-009 The block SHALL have port cmd_wdata, input, 8 bits: write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 8 bits: read data, held until the next read completes.
REQ-012 The block SHALL have port rsp_nack, output, 1 bit: the slave NACKed; valid with rsp_valid.
REQ-013 The block SHALL have port scl_out, output, 1 bit: SCL level (1 = released high).
REQ-014 The block SHALL have port sda_in, input, 1 bit: sampled SDA.
REQ-015 The block SHALL have port sda_out, output, 1 bit: driven SDA value.
REQ-016 The block SHALL have port out_write_enable, output, 1 bit: 1 = drive SDA, 0 = release SDA (input).
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-018 A command SHALL be accepted on a clk edge where cmd_valid && cmd_ready; cmd_rw, cmd_addr and cmd_wdata are latched on that edge, and cmd_valid while busy is ignored.
REQ-019 Each bit slot SHALL be four quarters of QUARTER clk cycles each: SCL low, low, high, high. SDA changes only at the start of quarter 0, and sda_in is sampled at the last cycle of quarter 2.
REQ-020 The write sequence SHALL be: START, {DEVICE_ADDRESS,0}, ACK, {4'b0,cmd_addr}, ACK, cmd_wdata, ACK, STOP.
REQ-021 The read sequence SHALL be: START, {DEVICE_ADDRESS,0}, ACK, {4'b0,cmd_addr}, ACK, repeated START, {DEVICE_ADDRESS,1}, ACK, 8 data bits (MSB first), master NACK (SDA=1), STOP.
REQ-022 START and repeated START SHALL be: SDA falls while SCL is high, held for 2 quarters, then SCL falls. STOP SHALL be: SDA low, SCL rises, then after 2 quarters SDA rises.
REQ-023 The FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RSTART, RADDR, RADDR_ACK, RDATA, MNACK, STOP.
REQ-024 Bytes SHALL be sent MSB first using a 3-bit bit counter that wraps from 7 to 0 on entry to each ACK slot.
REQ-025 During ACK slots and RDATA, out_write_enable SHALL be 0; otherwise it SHALL be 1.
REQ-026 If sda_in is 1 in any slave ACK slot, the FSM SHALL go directly to STOP, skip remaining bytes, and set rsp_nack=1.
REQ-027 rsp_valid SHALL pulse exactly one cycle on the clk after STOP completes, with the FSM returning to IDLE on the same edge; cmd_ready SHALL be high on the following cycle.
REQ-028 rsp_rdata SHALL update only on a read that completes without NACK.

Reset
REQ-029 While rst=1 the block SHALL force: state IDLE, scl_out=1, sda_out=1, out_write_enable=0, busy=0, cmd_ready=0, rsp_valid=0, rsp_nack=0, rsp_rdata=8'h00, and all counters 0; cmd_ready SHALL be 1 on the first cycle after rst is released.
REQ-030 A reset during a transfer SHALL abort it immediately without a STOP and with no rsp_valid.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the R/W bit constants and the default DEVICE_ADDRESS.
REQ-032 The block SHALL contain one sub-module, i2c_scl_gen: a quarter-period counter producing the phase (0..3) and a phase-end strobe.

Verification
REQ-033 The bench SHALL cover: write with cmd_addr=4'h3, cmd_wdata=8'hA5, slave ACKs all -> SDA bytes 8'h54, 8'h03, 8'hA5, then STOP, rsp_valid=1, rsp_nack=0.
REQ-034 The bench SHALL cover: read with cmd_addr=4'h7, slave returns 8'h3C -> bytes 8'h54, 8'h07, Sr, 8'h55, master NACK, STOP, rsp_rdata=8'h3C.
REQ-035 The bench SHALL cover: slave NACK on the address byte -> STOP right after ADDR_ACK, rsp_nack=1, rsp_rdata unchanged.
REQ-036 The bench SHALL cover: cmd_valid held high during a transfer -> exactly one transaction, then cmd_ready=1 after rsp_valid.
REQ-037 The bench SHALL cover: rst asserted mid-WDATA -> next cycle scl_out=1, out_write_enable=0, busy=0, and no rsp_valid.
REQ-038 The bench SHALL cover: QUARTER=1 -> each bit lasts 4 clk cycles, and the write transaction of REQ-033 completes with correct bytes.
